// File: rtl/fetch_queue_if.sv
// Handshake and FIFO-control bundle between fetch, decode and the fetch queue controller.
// Both handshakes are valid/ready: a transfer happens on a rising edge where valid && ready,
// valid must not wait on ready, and an offered packet is held until it is taken or flushed.
interface fetch_queue_if #(
  parameter int CNT_W = 4
);
  logic             fetch_valid;
  logic             fetch_ready;
  logic             dec_ready;
  logic             dec_stall;
  logic             flush;
  logic             fifo_full;
  logic             fifo_write;
  logic             fifo_read;
  logic             fifo_stall;
  logic             fifo_clear;
  logic             dec_valid;
  logic [CNT_W-1:0] count;
  logic [1:0]       state;

  modport master (
    input  fetch_valid, dec_ready, dec_stall, flush, fifo_full,
    output fetch_ready, fifo_write, fifo_read, fifo_stall, fifo_clear, dec_valid, count, state
  );

  modport slave (
    output fetch_valid, dec_ready, dec_stall, flush, fifo_full,
    input  fetch_ready, fifo_write, fifo_read, fifo_stall, fifo_clear, dec_valid, count, state
  );
endinterface

// File: rtl/fetch_queue_ctrl.sv
// Fetch-to-decode instruction-pair queue controller: occupancy, strobes and flush/refill FSM.
// Optional FQ_PERF_CNT_EN adds saturating decode-starve and fetch-blocked counters.
module fetch_queue_ctrl #(
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH) + 1,
  parameter int REFILL_MIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  fetch_queue_if.master     bus
`ifdef FQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_starve,
  output logic [31:0]       perf_full
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FLUSH  = 2'b10,
    S_REFILL = 2'b11
  } fq_state_e;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] REFILL_C = CNT_W'(REFILL_MIN);

  fq_state_e        state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_next;
  logic             fetch_ready;
  logic             fifo_write;
  logic             dec_valid;
  logic             fifo_read;
  logic             fifo_stall;
  logic             fifo_clear;

  // Strobes are gated by rst so nothing fires while reset is held.
  always_comb begin
    fetch_ready = !rst && (state_q != S_FLUSH) && (count_q != DEPTH_C) && !bus.fifo_full;
    fifo_write  = bus.fetch_valid && fetch_ready;
    dec_valid   = !rst && (state_q == S_RUN) && (count_q != '0);
    fifo_read   = dec_valid && bus.dec_ready && !bus.dec_stall;
    fifo_stall  = !rst && (bus.dec_stall || (state_q == S_FLUSH));
    fifo_clear  = !rst && (state_q == S_FLUSH);
    count_next  = count_q + CNT_W'(fifo_write) - CNT_W'(fifo_read);
  end

  assign bus.fetch_ready = fetch_ready;
  assign bus.fifo_write  = fifo_write;
  assign bus.dec_valid   = dec_valid;
  assign bus.fifo_read   = fifo_read;
  assign bus.fifo_stall  = fifo_stall;
  assign bus.fifo_clear  = fifo_clear;
  assign bus.count       = count_q;
  assign bus.state       = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else if (bus.flush) begin
      // A packet written on the flush edge is wrong-path; the clear in FLUSH discards it.
      state_q <= S_FLUSH;
      count_q <= '0;
    end else begin
      count_q <= count_next;
      case (state_q)
        S_IDLE:   if (fifo_write) state_q <= S_RUN;
        S_RUN:    if ((count_next == '0) && !bus.fetch_valid) state_q <= S_IDLE;
        S_FLUSH:  state_q <= S_REFILL;
        S_REFILL: begin
          // Short fetch block: release decode early rather than wait for REFILL_MIN.
          if ((count_next >= REFILL_C) || ((count_next != '0) && !bus.fetch_valid))
            state_q <= S_RUN;
        end
        default:  state_q <= S_IDLE;
      endcase
    end
  end

`ifdef FQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_starve <= '0;
      perf_full   <= '0;
    end else begin
      if ((state_q == S_RUN) && (count_q == '0) && bus.dec_ready && (perf_starve != '1))
        perf_starve <= perf_starve + 32'd1;
      if (bus.fetch_valid && !fetch_ready && (state_q != S_FLUSH) && (perf_full != '1))
        perf_full <= perf_full + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Directed and random checks of fetch_queue_ctrl against a queue-based reference model.
module tb_fetch_queue_ctrl;
  localparam int DEPTH      = 8;
  localparam int CNT_W      = 4;
  localparam int REFILL_MIN = 2;
  localparam int M_IDLE     = 0;
  localparam int M_RUN      = 1;
  localparam int M_FLUSH    = 2;
  localparam int M_REFILL   = 3;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.CNT_W(CNT_W)) bus ();

`ifdef FQ_PERF_CNT_EN
  logic [31:0] perf_starve;
  logic [31:0] perf_full;
`endif

  fetch_queue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .REFILL_MIN(REFILL_MIN)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master)
`ifdef FQ_PERF_CNT_EN
    ,
    .perf_starve (perf_starve),
    .perf_full   (perf_full)
`endif
  );

  // reference model: packet sequence numbers held in the modelled FIFO
  logic [15:0] exp_q[$];
  int          mode     = M_IDLE;
  int          seq      = 0;
  logic [31:0] m_starve = '0;
  logic [31:0] m_full   = '0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: apply one cycle of inputs, check outputs before the edge, advance the model
  task automatic step(input logic r, input logic fv, input logic dr, input logic ds,
                      input logic fl, input logic ff);
    bit e_fr, e_wr, e_dv, e_rd, e_st, e_cl;
    int n;
    @(negedge clk);
    rst               = r;
    bus.fetch_valid   = fv;
    bus.dec_ready     = dr;
    bus.dec_stall     = ds;
    bus.flush         = fl;
    bus.fifo_full     = ff;
    #1;
    n    = exp_q.size();
    e_fr = !r && (mode != M_FLUSH) && (n < DEPTH) && !ff;
    e_wr = fv && e_fr;
    e_dv = !r && (mode == M_RUN) && (n > 0);
    e_rd = e_dv && dr && !ds;
    e_st = !r && (ds || (mode == M_FLUSH));
    e_cl = !r && (mode == M_FLUSH);
    chk("state",       64'(bus.state),       64'(mode));
    chk("count",       64'(bus.count),       64'(n));
    chk("fetch_ready", 64'(bus.fetch_ready), 64'(e_fr));
    chk("fifo_write",  64'(bus.fifo_write),  64'(e_wr));
    chk("dec_valid",   64'(bus.dec_valid),   64'(e_dv));
    chk("fifo_read",   64'(bus.fifo_read),   64'(e_rd));
    chk("fifo_stall",  64'(bus.fifo_stall),  64'(e_st));
    chk("fifo_clear",  64'(bus.fifo_clear),  64'(e_cl));
`ifdef FQ_PERF_CNT_EN
    chk("perf_starve", 64'(perf_starve), 64'(m_starve));
    chk("perf_full",   64'(perf_full),   64'(m_full));
`endif
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      mode     = M_IDLE;
      m_starve = '0;
      m_full   = '0;
    end else begin
      if ((mode == M_RUN) && (n == 0) && dr && (m_starve != 32'hFFFF_FFFF)) m_starve++;
      if (fv && !e_fr && (mode != M_FLUSH) && (m_full != 32'hFFFF_FFFF)) m_full++;
      if (e_rd) void'(exp_q.pop_front());
      if (e_wr) begin
        exp_q.push_back(16'(seq));
        seq++;
      end
      if (fl) begin
        exp_q.delete();
        mode = M_FLUSH;
      end else begin
        case (mode)
          M_IDLE:   if (e_wr) mode = M_RUN;
          M_RUN:    if ((exp_q.size() == 0) && !fv) mode = M_IDLE;
          M_FLUSH:  mode = M_REFILL;
          default:  if ((exp_q.size() >= REFILL_MIN) || ((exp_q.size() != 0) && !fv)) mode = M_RUN;
        endcase
      end
    end
    #1;
  endtask

  task automatic do_reset();
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.fetch_valid = 1'b0;
    bus.dec_ready   = 1'b0;
    bus.dec_stall   = 1'b0;
    bus.flush       = 1'b0;
    bus.fifo_full   = 1'b0;
    @(posedge clk);
    #1;

    // reset: every output 0 while rst is held
    do_reset();
    chk("reset_state", 64'(bus.state), 64'd0);
    chk("reset_count", 64'(bus.count), 64'd0);

    // fill to full with decode blocked
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fill_count", 64'(bus.count), 64'd8);
    chk("fill_ready", 64'(bus.fetch_ready), 64'd0);
    chk("fill_state", 64'(bus.state), 64'd1);

    // streaming with a two-cycle backend stall
    do_reset();
    for (int i = 1; i <= 8; i++)
      step(1'b0, 1'b1, 1'b1, (i == 3) || (i == 4), 1'b0, 1'b0);
    chk("stream_count", 64'(bus.count), 64'd3);

    // flush at count=5, then refill
    do_reset();
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_count", 64'(bus.count), 64'd5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_state", 64'(bus.state), 64'd2);
    chk("flush_count", 64'(bus.count), 64'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("refill_state", 64'(bus.state), 64'd3);
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("refill_run", 64'(bus.state), 64'd1);
    chk("refill_dv", 64'(bus.dec_valid), 64'd1);

    // back-to-back flush during REFILL
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("b2b_state", 64'(bus.state), 64'd2);
      chk("b2b_count", 64'(bus.count), 64'd0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_refill", 64'(bus.state), 64'd3);
    chk("b2b_refill_count", 64'(bus.count), 64'd0);

    // mid-operation reset wins over flush and writes
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("midrst_state", 64'(bus.state), 64'd0);
    chk("midrst_count", 64'(bus.count), 64'd0);

    // randomized traffic
    do_reset();
    repeat (600)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);

`ifdef FQ_PERF_CNT_EN
    // decode starved in RUN at count=0
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("perf_starve6", 64'(perf_starve), 64'd6);
    // fetch blocked by a full FIFO
    do_reset();
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("perf_full3", 64'(perf_full), 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
